sample_strobe: RTL and testbench

Sample-strobe generator sitting directly downstream of the correlator's BytePipe register block. It consumes the `sampleRateNegExp`, `sampleMode` and `sampleJitterNegExp` register outputs. From them it produces a single-cycle `o_strobe` that tells the correlator datapath when to capture its inputs. Strobes are either strictly periodic or periodic with LFSR-driven interval jitter.

---
 rtl/sample_strobe_pkg.sv | 31 +++
 rtl/sample_strobe_lfsr_galois32.sv | 26 ++
 rtl/sample_strobe.sv | 114 +++++++++++
 tb/tb_sample_strobe.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/sample_strobe_pkg.sv
// Shared types and helpers for the correlator sample-strobe generator.
// Holds the sample-mode encodings, the jitter LFSR taps and the interval calculation.
package samplePkg;

  localparam logic SAMPLE_MODE_NONJITTER   = 1'd0;
  localparam logic SAMPLE_MODE_NONPERIODIC = 1'd1;

  // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
  localparam logic [31:0] LFSR_TAPS = 32'h80200003;

  // Interval length in cycles: 2^re when jw is 0, otherwise 2^re centred
  // on a window of 2^jw lengths picked by the low jw bits of rnd.
  function automatic logic [31:0] intervalLen(
    input logic [5:0]  re,
    input logic [5:0]  jw,
    input logic [31:0] rnd
  );
    logic [31:0] base;
    logic [31:0] half;
    logic [31:0] mask;
    base = 32'd1 << re;
    if (jw == 6'd0) begin
      intervalLen = base;
    end else begin
      half = 32'd1 << (jw - 6'd1);
      mask = (32'd1 << jw) - 32'd1;
      intervalLen = base - half + (rnd & mask);
    end
  endfunction

endpackage

// File: rtl/sample_strobe_lfsr_galois32.sv
// 32-bit Galois LFSR, one step per enabled cycle; state is never zero for a nonzero seed.
// Output is the current register state; i_cg low holds the state.
module lfsr_galois32
  import samplePkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE12345
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cg,
  output logic [31:0] o_state
);

  logic [31:0] stateQ;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stateQ <= SEED;
    end else if (i_cg) begin
      stateQ <= stateQ[0] ? ((stateQ >> 1) ^ LFSR_TAPS) : (stateQ >> 1);
    end
  end

  assign o_state = stateQ;

endmodule

// File: rtl/sample_strobe.sv
// Periodic / LFSR-jittered single-cycle sample strobe for the correlator datapath.
// Strobe decided from cnt_q in cycle N, visible in N+1; i_cg low freezes all state and holds the strobe low.
module sample_strobe
  import samplePkg::*;
#(
  parameter int          MAX_SAMPLE_RATE_NEGEXP   = 31,
  parameter int          MAX_SAMPLE_JITTER_NEGEXP = 31,
  parameter logic [31:0] LFSR_SEED                = 32'hACE12345
) (
  input  logic                                        i_clk,
  input  logic                                        i_rst,
  input  logic                                        i_cg,
  input  logic [$clog2(MAX_SAMPLE_RATE_NEGEXP)-1:0]   i_sampleRateNegExp,
  input  logic                                        i_sampleMode,
  input  logic [$clog2(MAX_SAMPLE_JITTER_NEGEXP)-1:0] i_sampleJitterNegExp,
  output logic                                        o_strobe,
  output logic [15:0]                                 o_strobeCount
);

  localparam int RW    = $clog2(MAX_SAMPLE_RATE_NEGEXP);
  localparam int JW    = $clog2(MAX_SAMPLE_JITTER_NEGEXP);
  localparam int CNT_W = MAX_SAMPLE_RATE_NEGEXP + 1;
  localparam logic [5:0] MAX_RE = 6'(MAX_SAMPLE_RATE_NEGEXP);

  logic [RW-1:0]    rateQ;
  logic             modeQ;
  logic [JW-1:0]    jitterQ;
  logic             cfgChanged;

  logic [5:0]       rateEff;
  logic [5:0]       jitterExt;
  logic [5:0]       jitterWidth;
  logic [31:0]      lenNext;
  logic [CNT_W-1:0] cntReload;
  logic [CNT_W-1:0] cntQ;
  logic [31:0]      lfsrQ;
  logic             strobeD;
  logic [15:0]      strobeCountQ;

  lfsr_galois32 #(
    .SEED (LFSR_SEED)
  ) uLfsr (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_cg    (i_cg),
    .o_state (lfsrQ)
  );

  assign cfgChanged = (i_sampleRateNegExp   != rateQ)  ||
                      (i_sampleMode         != modeQ)  ||
                      (i_sampleJitterNegExp != jitterQ);

  // Interval is always computed from the live config so a change reloads
  // the counter with the new period in the same cycle it is seen.
  always_comb begin
    rateEff     = 6'(i_sampleRateNegExp);
    jitterExt   = 6'(i_sampleJitterNegExp);
    jitterWidth = 6'd0;
    if (rateEff > MAX_RE) begin
      rateEff = MAX_RE;
    end
    if ((i_sampleMode == SAMPLE_MODE_NONPERIODIC) && (rateEff > jitterExt)) begin
      jitterWidth = rateEff - jitterExt;
    end
  end

  assign lenNext   = intervalLen(rateEff, jitterWidth, lfsrQ);
  assign cntReload = lenNext[CNT_W-1:0] - CNT_W'(1);
  assign strobeD   = i_cg && (cntQ == '0) && !cfgChanged;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rateQ   <= '0;
      modeQ   <= SAMPLE_MODE_NONJITTER;
      jitterQ <= '0;
    end else if (i_cg) begin
      rateQ   <= i_sampleRateNegExp;
      modeQ   <= i_sampleMode;
      jitterQ <= i_sampleJitterNegExp;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cntQ <= '0;
    end else if (i_cg) begin
      if (cfgChanged || (cntQ == '0)) begin
        cntQ <= cntReload;
      end else begin
        cntQ <= cntQ - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      strobeCountQ <= 16'd0;
    end else if (strobeD) begin
      strobeCountQ <= strobeCountQ + 16'd1;
    end
  end

  // Ungated so a gated cycle always returns the strobe low.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_strobe <= 1'b0;
    end else begin
      o_strobe <= strobeD;
    end
  end

  assign o_strobeCount = strobeCountQ;

endmodule

// File: tb/tb_sample_strobe.sv
// Directed bench for sample_strobe: a per-cycle vector table plus multi-cycle
// sequences for periodic, jittered, config-change, gating, wrap and reset behaviour.
module tb_sample_strobe;

  logic        clk = 1'b0;
  logic        rst;
  logic        cg;
  logic [4:0]  rate;
  logic        mode;
  logic [4:0]  jit;
  logic        strobe;
  logic [15:0] strobeCount;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  sample_strobe dut (
    .i_clk                (clk),
    .i_rst                (rst),
    .i_cg                 (cg),
    .i_sampleRateNegExp   (rate),
    .i_sampleMode         (mode),
    .i_sampleJitterNegExp (jit),
    .o_strobe             (strobe),
    .o_strobeCount        (strobeCount)
  );

  typedef struct {
    logic        rst;
    logic        cg;
    logic [4:0]  rate;
    logic        mode;
    logic [4:0]  jit;
    logic        expStrobe;
    logic [15:0] expCount;
  } vec_t;

  localparam int NVEC = 30;
  vec_t vecs [NVEC];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lfsrNext(input logic [31:0] s);
    lfsrNext = s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
  endfunction

  function automatic int lenModel(input int r, input int m, input int j, input logic [31:0] rnd);
    int jw;
    jw = (m == 1 && r > j) ? r - j : 0;
    if (jw == 0) return 1 << r;
    return (1 << r) - (1 << (jw - 1)) + int'(rnd & ((32'd1 << jw) - 32'd1));
  endfunction

  function automatic vec_t mk(input logic r, input logic g, input logic [4:0] ra,
                              input logic m, input logic [4:0] j,
                              input logic es, input logic [15:0] ec);
    vec_t v;
    v.rst = r; v.cg = g; v.rate = ra; v.mode = m; v.jit = j;
    v.expStrobe = es; v.expCount = ec;
    return v;
  endfunction

  task automatic resetWith(input logic [4:0] ra, input logic m, input logic [4:0] j);
    rst = 1'b1; cg = 1'b1; rate = ra; mode = m; jit = j;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int nextDec;
    int lastDec;
    int nStrobes;
    int meas;
    int seenCnt;
    logic [31:0] lfsrM;
    bit seen [8];

    rst = 1'b1; cg = 1'b1; rate = 5'd0; mode = 1'b0; jit = 5'd0;

    // inputs for one cycle -> outputs visible after its closing edge
    vecs[0]  = mk(1, 1, 0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 1, 0, 0, 0, 0, 0);
    vecs[2]  = mk(0, 1, 0, 0, 0, 1, 1);
    vecs[3]  = mk(0, 1, 0, 0, 0, 1, 2);
    vecs[4]  = mk(0, 1, 0, 0, 0, 1, 3);
    vecs[5]  = mk(0, 0, 0, 0, 0, 0, 3);
    vecs[6]  = mk(0, 1, 0, 0, 0, 1, 4);
    vecs[7]  = mk(0, 1, 2, 0, 0, 0, 4);
    vecs[8]  = mk(0, 1, 2, 0, 0, 0, 4);
    vecs[9]  = mk(0, 1, 2, 0, 0, 0, 4);
    vecs[10] = mk(0, 1, 2, 0, 0, 0, 4);
    vecs[11] = mk(0, 1, 2, 0, 0, 1, 5);
    vecs[12] = mk(0, 1, 2, 0, 0, 0, 5);
    vecs[13] = mk(0, 1, 2, 0, 0, 0, 5);
    vecs[14] = mk(0, 1, 2, 0, 0, 0, 5);
    vecs[15] = mk(0, 1, 2, 0, 0, 1, 6);
    vecs[16] = mk(1, 1, 2, 0, 0, 0, 0);
    vecs[17] = mk(0, 1, 2, 0, 0, 0, 0);
    vecs[18] = mk(0, 1, 2, 0, 0, 0, 0);
    vecs[19] = mk(0, 1, 2, 0, 0, 0, 0);
    vecs[20] = mk(0, 1, 2, 0, 0, 0, 0);
    vecs[21] = mk(0, 1, 2, 0, 0, 1, 1);
    vecs[22] = mk(0, 1, 2, 1, 5, 0, 1);
    vecs[23] = mk(0, 1, 2, 1, 5, 0, 1);
    vecs[24] = mk(0, 1, 2, 1, 5, 0, 1);
    vecs[25] = mk(0, 1, 2, 1, 5, 0, 1);
    vecs[26] = mk(0, 1, 2, 1, 5, 1, 2);
    vecs[27] = mk(0, 1, 0, 0, 0, 0, 2);
    vecs[28] = mk(0, 1, 0, 0, 0, 1, 3);
    vecs[29] = mk(0, 1, 0, 0, 0, 1, 4);

    for (int i = 0; i < NVEC; i++) begin
      rst = vecs[i].rst; cg = vecs[i].cg; rate = vecs[i].rate;
      mode = vecs[i].mode; jit = vecs[i].jit;
      step();
      check($sformatf("vec%0d_strobe", i), 32'(strobe), 32'(vecs[i].expStrobe));
      check($sformatf("vec%0d_count", i), 32'(strobeCount), 32'(vecs[i].expCount));
    end

    // R=3 periodic: cycle 0 is a config change, then decisions every 8 cycles
    resetWith(5'd3, 1'b0, 5'd0);
    nextDec = 8;
    for (int c = 0; c < 808; c++) begin
      step();
      check($sformatf("periodic_c%0d", c), 32'(strobe), 32'(c == nextDec));
      if (c == nextDec) nextDec += 8;
    end
    check("periodic_count", 32'(strobeCount), 32'd100);

    // R=4, J=1, mode 1: Jw=3, intervals in [12,19] following the LFSR
    resetWith(5'd4, 1'b1, 5'd1);
    lfsrM    = 32'hACE12345;
    nextDec  = lenModel(4, 1, 1, lfsrM);
    lastDec  = 0;
    nStrobes = 0;
    for (int k = 0; k < 8; k++) seen[k] = 1'b0;
    for (int c = 0; c < 9000 && nStrobes < 400; c++) begin
      step();
      check($sformatf("jitter_c%0d", c), 32'(strobe), 32'(c == nextDec));
      if (strobe) begin
        meas = c - lastDec;
        lastDec = c;
        nStrobes++;
        if (meas >= 12 && meas <= 19) seen[meas - 12] = 1'b1;
        else check("jitter_range", 32'(meas), 32'd12);
      end
      if (c == nextDec) nextDec += lenModel(4, 1, 1, lfsrM);
      lfsrM = lfsrNext(lfsrM);
    end
    check("jitter_strobes", 32'(nStrobes), 32'd400);
    seenCnt = 0;
    for (int k = 0; k < 8; k++) if (seen[k]) seenCnt++;
    check("jitter_all_lengths", 32'(seenCnt), 32'd8);

    // R 20 -> 1 in cycle 50: no strobe then, reload 1, decision at 52, then every 2
    resetWith(5'd20, 1'b0, 5'd0);
    for (int c = 0; c < 50; c++) begin
      step();
      check($sformatf("shorten_pre_c%0d", c), 32'(strobe), 32'd0);
    end
    rate = 5'd1;
    for (int c = 50; c < 62; c++) begin
      step();
      check($sformatf("shorten_c%0d", c), 32'(strobe), 32'(c >= 52 && ((c - 52) % 2 == 0)));
    end

    // R=2, i_cg low in cycles 10..14: decision due at 12 slips to 17
    resetWith(5'd2, 1'b0, 5'd0);
    for (int c = 0; c < 26; c++) begin
      cg = !(c >= 10 && c <= 14);
      step();
      check($sformatf("gate_c%0d", c), 32'(strobe),
            32'(c == 4 || c == 8 || c == 17 || c == 21 || c == 25));
    end
    cg = 1'b1;

    // R=0 strobes every cycle: drive the count to 0xFFFF, then wrap
    resetWith(5'd0, 1'b0, 5'd0);
    repeat (65535) step();
    check("wrap_ffff", 32'(strobeCount), 32'hFFFF);
    check("wrap_strobe", 32'(strobe), 32'd1);
    step();
    check("wrap_zero", 32'(strobeCount), 32'h0000);

    // reset mid-interval drops any in-flight strobe
    rate = 5'd2;
    step();
    step();
    step();
    step();
    step();
    check("midreset_pre_strobe", 32'(strobe), 32'd1);
    rst = 1'b1;
    step();
    check("midreset_strobe", 32'(strobe), 32'd0);
    check("midreset_count", 32'(strobeCount), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
